// File: rtl/div_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
// Holds the FSM state encoding and the step-counter width derivation.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_N_DEF = 4;

    // The counter must be able to hold the values 0..N.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_N_DEF);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports: i_p partial remainder, i_bit next dividend bit, i_div divisor,
//        o_p updated partial remainder, o_qbit quotient bit produced.
module div_step
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_p,
    input  logic         i_bit,
    input  logic [N-1:0] i_div,
    output logic [N-1:0] o_p,
    output logic         o_qbit
);

    logic [N:0] w_t;

    assign w_t    = {i_p, i_bit};
    assign o_qbit = (w_t >= {1'b0, i_div});

    // Only the low N bits of the new remainder can influence anything:
    // the next step shifts the top bit out and the result is P[N-1:0].
    assign o_p = o_qbit ? N'(w_t - {1'b0, i_div}) : w_t[N-1:0];

endmodule

// File: rtl/div8u_by4u_seq.sv
// Sequential unsigned divider: 2N-bit dividend by N-bit divisor, one
// restoring step per cycle, valid/ready on both sides.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with dividend,
//        divisor; out_valid/out_ready with quotient, remainder, err.
// Option: define DIV_OVF_DET_EN to flag divide-by-zero / quotient
//         overflow at acceptance (err=1, quotient all ones, remainder 0,
//         result after one cycle). Without it err is tied low.
module div8u_by4u_seq
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           err
);

    localparam int CNT_W = cnt_width(N);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_p;
    logic [N-1:0]     r_sh;
    logic [N-1:0]     r_div;
    logic [N-1:0]     r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_ovf;
    logic             w_qbit;
    logic [N-1:0]     w_p_nxt;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CNT_W'(N - 1));

`ifdef DIV_OVF_DET_EN
    logic r_err;

    // A high half at or above the divisor cannot yield an N-bit quotient.
    assign w_ovf = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
    assign err   = r_err;
`else
    assign w_ovf = 1'b0;
    assign err   = 1'b0;
`endif

    div_step #(
        .N(N)
    ) u_step (
        .i_p   (r_p),
        .i_bit (r_sh[N-1]),
        .i_div (r_div),
        .o_p   (w_p_nxt),
        .o_qbit(w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_ovf ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_sh  <= '0;
            r_div <= '0;
            r_quo <= '0;
            r_cnt <= '0;
`ifdef DIV_OVF_DET_EN
            r_err <= 1'b0;
`endif
        end else if (w_accept) begin
            r_sh  <= dividend[N-1:0];
            r_div <= divisor;
            r_cnt <= '0;
`ifdef DIV_OVF_DET_EN
            r_err <= w_ovf;
`endif
            if (w_ovf) begin
                r_p   <= '0;
                r_quo <= '1;
            end else begin
                r_p   <= dividend[2*N-1:N];
                r_quo <= '0;
            end
        end else if (r_state == BUSY) begin
            r_p   <= w_p_nxt;
            r_sh  <= {r_sh[N-2:0], 1'b0};
            r_quo <= {r_quo[N-2:0], w_qbit};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_p;

endmodule

// File: tb/tb_div8u_by4u_seq.sv
// Self-checking bench for div8u_by4u_seq (N=4): vector table, handshake
// corner cases, reset abort, back-to-back traffic, product sweep.
module tb_div8u_by4u_seq;

    localparam int N = 4;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       e;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] dd;
        logic [3:0] dv;
        logic [3:0] q;
        logic [3:0] r;
        logic       e;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       err;

    int   checks;
    int   failures;
    exp_t sb[$];
    vec_t vt[10];

    div8u_by4u_seq #(
        .N(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] q, input logic [3:0] r,
                                input logic e);
        exp_t x;
        x.q   = q;
        x.r   = r;
        x.e   = e;
        x.lat = e ? 1 : N + 1;
        return x;
    endfunction

    // Restoring algorithm, written over plain integers.
    function automatic exp_t model(input logic [7:0] dd, input logic [3:0] dv);
        int         p;
        int         t;
        logic [3:0] q;
`ifdef DIV_OVF_DET_EN
        if (dv == 0 || dd[7:4] >= dv) return mk(4'hF, 4'h0, 1'b1);
`endif
        p = int'(dd[7:4]);
        q = 4'h0;
        for (int i = 3; i >= 0; i--) begin
            t = ((p % 16) * 2) + int'(dd[i]);
            if (t >= int'(dv)) begin
                p = t - int'(dv);
                q = {q[2:0], 1'b1};
            end else begin
                p = t;
                q = {q[2:0], 1'b0};
            end
        end
        return mk(q, 4'(p % 16), 1'b0);
    endfunction

    task automatic send(input logic [7:0] dd, input logic [3:0] dv,
                        input exp_t e);
        int n;
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready got 0 required 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        sb.push_back(e);
    endtask

    task automatic recv(input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid || sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL recv_timeout: out_valid got %0d required 1",
                     out_valid);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("err", err, e.e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_quotient", quotient, e.q);
            chk("hold_remainder", remainder, e.r);
            chk("hold_err", err, e.e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("single_xfer", out_valid, 0);
        chk("idle_ready", in_ready, 1);
    endtask

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: unexpected output quotient %0d", name, quotient);
        end else begin
            e = sb.pop_front();
            chk(name, {err, remainder, quotient}, {e.e, e.r, e.q});
        end
    endtask

    initial begin
        int   accepts;
        int   last;
        int   n;
        exp_t e;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vt[0] = '{8'd225, 4'd15, 4'd15, 4'd0,  1'b0};
        vt[1] = '{8'd42,  4'd6,  4'd7,  4'd0,  1'b0};
        vt[2] = '{8'd239, 4'd15, 4'd15, 4'd14, 1'b0};
        vt[3] = '{8'd15,  4'd1,  4'd15, 4'd0,  1'b0};
        vt[4] = '{8'd1,   4'd15, 4'd0,  4'd1,  1'b0};
        vt[5] = '{8'd0,   4'd5,  4'd0,  4'd0,  1'b0};
        vt[6] = '{8'd100, 4'd7,  4'd14, 4'd2,  1'b0};
`ifdef DIV_OVF_DET_EN
        vt[7] = '{8'h37,  4'd0,  4'hF,  4'd0,  1'b1};
        vt[8] = '{8'hF0,  4'd3,  4'hF,  4'd0,  1'b1};
        vt[9] = '{8'hFF,  4'd15, 4'hF,  4'd0,  1'b1};
`else
        vt[7] = '{8'h37,  4'd0,  4'hF,  4'd7,  1'b0};
        vt[8] = '{8'hF0,  4'd3,  4'hF,  4'd3,  1'b0};
        vt[9] = '{8'hFF,  4'd15, 4'd8,  4'd7,  1'b0};
`endif

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send(vt[i].dd, vt[i].dv, mk(vt[i].q, vt[i].r, vt[i].e));
            recv(0);
        end

        // Consumer stalls three cycles on 100/7.
        send(8'd100, 4'd7, mk(4'd14, 4'd2, 1'b0));
        recv(3);

        // Reset during the third BUSY cycle aborts the operation.
        send(8'd200, 4'd13, mk(4'd15, 4'd5, 1'b0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        #1 rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_out", out_valid, 0);
        end
        send(8'h2A, 4'd6, mk(4'd7, 4'd0, 1'b0));
        recv(0);

        // Back-to-back: in_valid and out_ready held high.
        e         = mk(4'd14, 4'd2, 1'b0);
        dividend  = 8'd100;
        divisor   = 4'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        accepts   = 0;
        last      = -1;
        for (int i = 0; i < 26; i++) begin
            if (i == 25) in_valid = 1'b0;
            chk("b2b_ready_excl", in_ready & out_valid, 0);
            if (in_ready && in_valid) begin
                if (last >= 0) chk("b2b_interval", i - last, N + 2);
                last = i;
                accepts++;
                sb.push_back(e);
            end
            if (out_valid) pop_cmp("b2b_result");
            @(negedge clk);
        end
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            if (out_valid) pop_cmp("b2b_drain");
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL b2b_drain_timeout: pending %0d required 0", sb.size());
            sb.delete();
        end
        out_ready = 1'b0;
        chk("b2b_accepts", accepts, 5);
        @(negedge clk);

        // Every a*b product divides back exactly.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                send(8'(a * b), 4'(b), mk(4'(a), 4'd0, 1'b0));
                recv(0);
            end
        end

        // Random operands against the algorithm model.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] rd;
            logic [3:0] rv;
            rd = 8'($urandom);
            rv = 4'($urandom);
            send(rd, rv, model(rd, rv));
            recv(i % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
